// File: rtl/creek_multi_ctrl.sv
// Multi-core creek controller: Avalon-MM register block for per-core run/resume,
// shared instruction-memory loader and a trace FIFO sampling the selected core.
module creek_multi_ctrl #(
  parameter int NUM_CORES        = 2,
  parameter int INSTR_ADDR_WIDTH = 10,
  parameter int INSTR_WIDTH      = 16,
  parameter int PC_WIDTH         = 10,
  parameter int STATE_WIDTH      = 5,
  parameter int TRACE_DEPTH      = 16
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [2:0]                           avs_address,
  input  logic                                 avs_read,
  input  logic                                 avs_write,
  input  logic [31:0]                          avs_writedata,
  output logic [31:0]                          avs_readdata,
  input  logic                                 local_init_done,
  input  logic [NUM_CORES-1:0]                 waiting,
  output logic [NUM_CORES-1:0]                 pause_n,
  output logic [NUM_CORES-1:0]                 resume,
  output logic [INSTR_ADDR_WIDTH-1:0]          instr_writeaddr,
  output logic [INSTR_WIDTH-1:0]               instr_writedata,
  output logic [NUM_CORES-1:0]                 instr_write,
  input  logic [NUM_CORES*PC_WIDTH-1:0]        cur_pc,
  input  logic [NUM_CORES*INSTR_WIDTH-1:0]     cur_instr,
  input  logic [NUM_CORES*STATE_WIDTH-1:0]     cur_state
);
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int TW = PC_WIDTH + INSTR_WIDTH + STATE_WIDTH;
  localparam int AW = $clog2(TRACE_DEPTH);
  localparam logic [2:0]  MAXC  = 3'(NUM_CORES - 1);
  localparam logic [AW:0] DEPTH = (AW+1)'(TRACE_DEPTH);
  localparam logic [2:0] A_SEL = 3'd0, A_RUN = 3'd1, A_RES = 3'd2, A_STAT = 3'd3,
                         A_IADDR = 3'd4, A_IDATA = 3'd5, A_TCTRL = 3'd6, A_TDATA = 3'd7;

  logic [2:0]                  r_sel_core;
  logic                        r_sel_bcast;
  logic [NUM_CORES-1:0]        r_pause_n, r_resume, r_instr_write;
  logic [INSTR_ADDR_WIDTH-1:0] r_iaddr, r_instr_writeaddr;
  logic [INSTR_WIDTH-1:0]      r_instr_writedata;
  logic                        r_resume_err, r_trace_ovf, r_tr_en, r_force;
  logic [31:0]                 r_readdata;
  logic [AW-1:0]               r_wptr, r_rptr;
  logic [AW:0]                 r_cnt;
  logic [PC_WIDTH-1:0]         r_last_pc;
  logic [STATE_WIDTH-1:0]      r_last_state;
  logic [TW-1:0]               r_mem [TRACE_DEPTH];

  logic [2:0]             w_core_raw;
  logic [CW-1:0]          w_core;
  logic [NUM_CORES-1:0]   w_target;
  logic                   w_wr_sel, w_wr_run, w_wr_res, w_wr_stat, w_wr_iaddr, w_wr_idata, w_wr_tctrl;
  logic                   w_clear, w_pop, w_full, w_push_req, w_push;
  logic [TW-1:0]          w_sample;
  logic [31:0]            w_rdata;
  logic                   w_unused;

  logic [PC_WIDTH-1:0]    w_pc_a    [NUM_CORES];
  logic [INSTR_WIDTH-1:0] w_instr_a [NUM_CORES];
  logic [STATE_WIDTH-1:0] w_state_a [NUM_CORES];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    assign w_pc_a[g]    = cur_pc[g*PC_WIDTH +: PC_WIDTH];
    assign w_instr_a[g] = cur_instr[g*INSTR_WIDTH +: INSTR_WIDTH];
    assign w_state_a[g] = cur_state[g*STATE_WIDTH +: STATE_WIDTH];
  end

  assign w_core_raw = (r_sel_core > MAXC) ? MAXC : r_sel_core;
  assign w_core     = CW'(w_core_raw);
  assign w_target   = r_sel_bcast ? '1 : (NUM_CORES'(1) << w_core);
  assign w_sample   = {w_state_a[w_core], w_instr_a[w_core], w_pc_a[w_core]};
  assign w_unused   = ^avs_writedata;

  assign w_wr_sel   = avs_write && avs_address == A_SEL;
  assign w_wr_run   = avs_write && avs_address == A_RUN;
  assign w_wr_res   = avs_write && avs_address == A_RES;
  assign w_wr_stat  = avs_write && avs_address == A_STAT;
  assign w_wr_iaddr = avs_write && avs_address == A_IADDR;
  assign w_wr_idata = avs_write && avs_address == A_IDATA;
  assign w_wr_tctrl = avs_write && avs_address == A_TCTRL;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign w_clear    = w_wr_tctrl && avs_writedata[1];
  assign w_pop      = avs_read && avs_address == A_TDATA && r_cnt != '0;
  assign w_full     = r_cnt == DEPTH;
  assign w_push_req = r_tr_en && (r_force || w_pc_a[w_core] != r_last_pc ||
                                  w_state_a[w_core] != r_last_state);
  assign w_push     = w_push_req && (!w_full || w_pop) && !w_clear;

  always_comb begin
    w_rdata = '0;
    case (avs_address)
      A_SEL:   begin w_rdata[2:0] = r_sel_core; w_rdata[7] = r_sel_bcast; end
      A_RUN:   w_rdata[NUM_CORES-1:0] = r_pause_n;
      A_STAT:  begin
        w_rdata[NUM_CORES-1:0] = waiting;
        w_rdata[16] = local_init_done;
        w_rdata[17] = r_resume_err;
        w_rdata[18] = r_trace_ovf;
      end
      A_IADDR: w_rdata[INSTR_ADDR_WIDTH-1:0] = r_iaddr;
      A_TCTRL: begin w_rdata[0] = r_tr_en; w_rdata[15:8] = 8'(r_cnt); end
      A_TDATA: if (r_cnt != '0) begin
        w_rdata[TW-1:0] = r_mem[r_rptr];
        w_rdata[31]     = 1'b1;
      end
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_core <= '0; r_sel_bcast <= 1'b0;
      r_pause_n <= '0; r_resume <= '0; r_resume_err <= 1'b0;
      r_iaddr <= '0; r_instr_write <= '0; r_instr_writeaddr <= '0; r_instr_writedata <= '0;
      r_readdata <= '0;
    end else begin
      if (w_wr_sel) begin
        r_sel_core  <= avs_writedata[2:0];
        r_sel_bcast <= avs_writedata[7];
      end
      if (!local_init_done)
        r_pause_n <= '0;
      else if (w_wr_run)
        r_pause_n <= avs_writedata[0] ? (r_pause_n | w_target) : (r_pause_n & ~w_target);
      r_resume <= w_wr_res ? (w_target & waiting) : '0;
      if (w_wr_res && |(w_target & ~waiting))
        r_resume_err <= 1'b1;
      else if (w_wr_stat && avs_writedata[17])
        r_resume_err <= 1'b0;
      if (w_wr_idata) begin
        r_instr_write     <= w_target;
        r_instr_writeaddr <= r_iaddr;
        r_instr_writedata <= avs_writedata[INSTR_WIDTH-1:0];
        r_iaddr           <= r_iaddr + INSTR_ADDR_WIDTH'(1);
      end else begin
        r_instr_write <= '0;
        if (w_wr_iaddr) r_iaddr <= avs_writedata[INSTR_ADDR_WIDTH-1:0];
      end
      if (avs_read) r_readdata <= w_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tr_en <= 1'b0; r_wptr <= '0; r_rptr <= '0; r_cnt <= '0;
      r_trace_ovf <= 1'b0; r_force <= 1'b1; r_last_pc <= '0; r_last_state <= '0;
    end else begin
      if (w_wr_tctrl) r_tr_en <= avs_writedata[0];
      if (w_clear) begin
        r_wptr <= '0; r_rptr <= '0; r_cnt <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
      if (w_push) begin
        r_last_pc    <= w_pc_a[w_core];
        r_last_state <= w_state_a[w_core];
      end
      // Forced sample stays pending until it actually lands in the FIFO.
      r_force <= !r_tr_en || w_wr_sel || (r_force && !w_push);
      if (w_push_req && w_full && !w_pop && !w_clear)
        r_trace_ovf <= 1'b1;
      else if (w_wr_stat && avs_writedata[18])
        r_trace_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_sample;
  end

  assign avs_readdata    = r_readdata;
  assign pause_n         = r_pause_n;
  assign resume          = r_resume;
  assign instr_write     = r_instr_write;
  assign instr_writeaddr = r_instr_writeaddr;
  assign instr_writedata = r_instr_writedata;
endmodule
